// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite-sheet fetch engine.
// Optional colour keying is enabled by defining SPRITE_FETCH_COLOR_KEY_EN.
package sprite_pkg;

  localparam int SHEET_W = 320;
  localparam int SHEET_H = 240;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 12;
  localparam int DIM_W   = 9;

  localparam logic [11:0] KEY_COLOR = 12'hF0F;

  typedef logic [11:0] rgb444_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_e;

  typedef struct packed {
    rgb444_t          data;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             last;
    logic             mask;
  } pix_entry_t;

endpackage

// File: rtl/sprite_fetch_if.sv
// Pixel stream from the sprite fetch engine to the line-buffer writer.
interface sprite_fetch_if
  import sprite_pkg::*;
();

  logic             pix_valid;
  logic             pix_ready;
  rgb444_t          pix_data;
  logic [DIM_W-1:0] pix_col;
  logic [DIM_W-1:0] pix_row;
  logic             pix_last;
  logic             pix_mask;

  modport master (
    output pix_valid, pix_data, pix_col, pix_row, pix_last, pix_mask,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_col, pix_row, pix_last, pix_mask,
    output pix_ready
  );

endinterface

// File: rtl/sprite_fetch_fifo.sv
// Two-entry output buffer holding returned ROM words with their tags.
module sprite_fetch_fifo
  import sprite_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       push,
  input  pix_entry_t push_entry,
  input  logic       pop,
  output pix_entry_t head,
  output logic [1:0] count
);

  pix_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sprite_fetch.sv
// Walks a sprite rectangle of the sheet ROM and streams its pixels in raster order.
// Define SPRITE_FETCH_COLOR_KEY_EN to derive pix_mask from KEY_COLOR.
module sprite_fetch
  import sprite_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  src_x,
  input  logic [DIM_W-1:0]  src_y,
  input  logic [DIM_W-1:0]  spr_w,
  input  logic [DIM_W-1:0]  spr_h,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  sprite_fetch_if.master    pix,
  output logic              busy,
  output logic              done
);

  fetch_state_e      state_q, state_d;
  logic [DIM_W-1:0]  w_q, h_q, col_q, row_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              in_flight_q;
  logic [DIM_W-1:0]  fl_col_q, fl_row_q;
  logic              fl_last_q;

  logic [1:0]        count;
  pix_entry_t        head;
  pix_entry_t        push_entry;
  logic              push_mask;
  logic              pop, issue, col_end, row_end, zero_size;
  logic [2:0]        credit_used, credit_cap;

  assign rom_addr    = row_base_q + ADDR_W'(col_q);
  assign pop         = pix.pix_valid & pix.pix_ready;
  assign col_end     = (col_q == w_q - DIM_W'(1));
  assign row_end     = (row_q == h_q - DIM_W'(1));
  assign zero_size   = (spr_w == '0) || (spr_h == '0);
  // a slot freed by this cycle's pop may be reused by this cycle's issue
  assign credit_used = {1'b0, count} + {2'b0, in_flight_q};
  assign credit_cap  = 3'd2 + {2'b0, pop};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = zero_size ? DONE : FETCH;
      FETCH: begin
        if (credit_used < credit_cap) begin
          issue = 1'b1;
          if (col_end && row_end) state_d = DRAIN;
        end
      end
      DRAIN: if (pop && head.last) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      in_flight_q <= 1'b0;
      fl_col_q    <= '0;
      fl_row_q    <= '0;
      fl_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= issue;
      if (state_q == IDLE && start) begin
        w_q        <= spr_w;
        h_q        <= spr_h;
        col_q      <= '0;
        row_q      <= '0;
        row_base_q <= ADDR_W'(src_y) * ADDR_W'(SHEET_W) + ADDR_W'(src_x);
      end else if (issue) begin
        fl_col_q  <= col_q;
        fl_row_q  <= row_q;
        fl_last_q <= col_end && row_end;
        if (col_end) begin
          col_q      <= '0;
          row_q      <= row_q + DIM_W'(1);
          row_base_q <= row_base_q + ADDR_W'(SHEET_W);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end
    end
  end

`ifdef SPRITE_FETCH_COLOR_KEY_EN
  assign push_mask = (rom_data != KEY_COLOR);
`else
  assign push_mask = 1'b1;
`endif

  assign push_entry = '{data: rom_data, col: fl_col_q, row: fl_row_q,
                        last: fl_last_q, mask: push_mask};

  sprite_fetch_fifo u_fifo (
    .Clk        (Clk),
    .Reset      (Reset),
    .push       (in_flight_q),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign pix.pix_valid = (count != 2'd0);
  assign pix.pix_data  = head.data;
  assign pix.pix_col   = head.col;
  assign pix.pix_row   = head.row;
  assign pix.pix_last  = head.last;
  assign pix.pix_mask  = head.mask;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a 1-cycle-latency sheet ROM model.
module tb_sprite_fetch;
  import sprite_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  src_x = '0, src_y = '0, spr_w = '0, spr_h = '0;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic              busy, done;

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_payload = '0;

  always #5 Clk = ~Clk;

  sprite_fetch_if pix_if ();

  sprite_fetch dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .src_x    (src_x),
    .src_y    (src_y),
    .spr_w    (spr_w),
    .spr_h    (spr_h),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pix      (pix_if),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [11:0] rom_word(input logic [19:0] a);
    if (a == 20'd50000) return 12'hF0F;
    if (a == 20'd50001) return 12'h123;
    return a[11:0] ^ 12'h5A5;
  endfunction

  always @(posedge Clk) rom_data <= rom_word(rom_addr);

  function automatic logic [31:0] exp_pix(input int addr, input int col, input int row,
                                          input logic last);
    logic [11:0] w;
    logic        m;
    w = rom_word(20'(addr));
`ifdef SPRITE_FETCH_COLOR_KEY_EN
    m = (w != 12'hF0F);
`else
    m = 1'b1;
`endif
    return {w, 9'(col), 9'(row), last, m};
  endfunction

  function automatic logic [31:0] obs_pix();
    return {pix_if.pix_data, pix_if.pix_col, pix_if.pix_row, pix_if.pix_last, pix_if.pix_mask};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stream monitor: records handshakes and checks payload stability under stall
  always @(negedge Clk) begin
    if (Reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", 40'({pix_if.pix_valid, obs_pix()}), 40'(prev_payload));
      if (pix_if.pix_valid && pix_if.pix_ready) q.push_back(obs_pix());
      prev_stall   = pix_if.pix_valid && !pix_if.pix_ready;
      prev_payload = {pix_if.pix_valid, obs_pix()};
    end
  end

  task automatic start_sprite(input int sx, input int sy, input int w, input int h);
    @(posedge Clk); #1;
    src_x = 9'(sx); src_y = 9'(sy); spr_w = 9'(w); spr_h = 9'(h);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 40'(got), 40'(1));
  endtask

  task automatic check_stream(input string tag, input int sx, input int sy,
                              input int w, input int h);
    int idx;
    chk({tag, "_count"}, 40'(q.size()), 40'(w * h));
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        idx = r * w + c;
        if (idx < q.size())
          chk($sformatf("%s_pix%0d", tag, idx), 40'(q[idx]),
              40'(exp_pix((sy + r) * 320 + sx + c, c, r, (r == h - 1) && (c == w - 1))));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_addr"},  40'(rom_addr), 40'(0));
    chk({tag, "_valid"}, 40'(pix_if.pix_valid), 40'(0));
    chk({tag, "_pix"},   40'(obs_pix()), 40'(0));
    chk({tag, "_busy"},  40'(busy), 40'(0));
    chk({tag, "_done"},  40'(done), 40'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [ADDR_W-1:0] a0;
    pix_if.pix_ready = 1'b1;

    // reset values
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle_outputs("rst");
    @(posedge Clk); #1;
    Reset = 1'b0;

    // 4x2 at origin, consumer always ready: cycle-exact timeline
    q.delete();
    start_sprite(0, 0, 4, 2);
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (k < 8) chk($sformatf("t1_addr%0d", k), 40'(rom_addr), 40'((k / 4) * 320 + k % 4));
      chk($sformatf("t1_valid%0d", k), 40'(pix_if.pix_valid), 40'(k >= 2 && k <= 9));
      chk($sformatf("t1_done%0d", k),  40'(done), 40'(k == 10));
      chk($sformatf("t1_busy%0d", k),  40'(busy), 40'(k <= 10));
      if (k >= 2 && k <= 9) begin
        p = k - 2;
        chk($sformatf("t1_pix%0d", p), 40'(obs_pix()),
            40'(exp_pix((p / 4) * 320 + p % 4, p % 4, p / 4, p == 7)));
      end
    end
    check_stream("t1", 0, 0, 4, 2);

    // 3x3 at (10,5), ready toggling, with a stray start that must be ignored
    q.delete();
    start_sprite(10, 5, 3, 3);
    @(negedge Clk);
    chk("t2_first_addr", 40'(rom_addr), 40'(1610));
    begin
      logic got;
      got = 1'b0;
      for (int n = 0; n < 60; n++) begin
        @(posedge Clk); #1;
        pix_if.pix_ready = ~pix_if.pix_ready;
        if (n == 3) begin
          start = 1'b1; src_x = 9'd0; src_y = 9'd0; spr_w = 9'd2; spr_h = 9'd2;
        end else begin
          start = 1'b0;
        end
        @(negedge Clk);
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      chk("t2_done_seen", 40'(got), 40'(1));
    end
    pix_if.pix_ready = 1'b1;
    check_stream("t2", 10, 5, 3, 3);

    // long stall mid-sprite: address generation must freeze
    q.delete();
    start_sprite(2, 3, 5, 2);
    repeat (3) @(negedge Clk);
    @(posedge Clk); #1;
    pix_if.pix_ready = 1'b0;
    repeat (3) @(negedge Clk);
    a0 = rom_addr;
    repeat (17) @(negedge Clk);
    chk("t3_addr_frozen", 40'(rom_addr), 40'(a0));
    chk("t3_valid_held",  40'(pix_if.pix_valid), 40'(1));
    chk("t3_busy_held",   40'(busy), 40'(1));
    @(posedge Clk); #1;
    pix_if.pix_ready = 1'b1;
    wait_done(40);
    check_stream("t3", 2, 3, 5, 2);

    // zero-width sprite, second start while in DONE is ignored
    q.delete();
    @(posedge Clk); #1;
    src_x = 9'd0; src_y = 9'd0; spr_w = 9'd0; spr_h = 9'd5;
    start = 1'b1;
    @(posedge Clk); #1;
    spr_w = 9'd2; spr_h = 9'd2;
    @(negedge Clk);
    chk("t4_done",  40'(done), 40'(1));
    chk("t4_busy",  40'(busy), 40'(1));
    chk("t4_valid", 40'(pix_if.pix_valid), 40'(0));
    @(posedge Clk); #1;
    start = 1'b0;
    @(negedge Clk);
    chk("t4_idle_busy", 40'(busy), 40'(0));
    chk("t4_idle_done", 40'(done), 40'(0));
    repeat (4) @(negedge Clk);
    chk("t4_still_idle", 40'(busy), 40'(0));
    chk("t4_no_pixels",  40'(q.size()), 40'(0));

    // reset mid-FETCH of an 8x8 sprite, then a clean 2x1 run
    start_sprite(0, 0, 8, 8);
    repeat (4) @(negedge Clk);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check_idle_outputs("t5_rst");
    @(posedge Clk); #1;
    Reset = 1'b0;
    q.delete();
    start_sprite(0, 0, 2, 1);
    wait_done(20);
    repeat (3) @(negedge Clk);
    check_stream("t5", 0, 0, 2, 1);

    // colour key words F0F and 123
    q.delete();
    start_sprite(80, 156, 2, 1);
    wait_done(20);
    check_stream("t6", 80, 156, 2, 1);
    if (q.size() == 2) begin
`ifdef SPRITE_FETCH_COLOR_KEY_EN
      chk("t6_mask0", 40'(q[0][0]), 40'(0));
`else
      chk("t6_mask0", 40'(q[0][0]), 40'(1));
`endif
      chk("t6_mask1", 40'(q[1][0]), 40'(1));
      chk("t6_data0", 40'(q[0][31:20]), 40'(12'hF0F));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
